retire_trace_buf: RTL and testbench
===================================

// Module: retire_trace_buf
// PURPOSE
// - Captures one retire record per cycle in which the single-cycle core asserts insn_vld_i.
// - Classifies each record and buffers it in a FIFO with a sequence number.
// - Drains records over a valid/ready port to the downstream trace logger.
// - Decouples the logger from core timing; reports loss on overflow and never stalls the core.
// PARAMETERS
// - DEPTH   16  FIFO entries; power of two, >= 2
// - SEQ_W   32  sequence counter width
// - DROP_W  16  drop counter width
// PORTS
// - clk_i       in   1   clock; all logic on rising edge
// - rst_i       in   1   reset, synchronous, active-high
// - insn_vld_i  in   1   core retired an instruction this cycle
// - pc_i        in   32  PC of retired instruction
// - instr_i     in   32  retired instruction word
// - wb_data_i   in   32  writeback data
// - ls_addr_i   in   12  load/store address (ALU result, low 12 b)
// - ld_data_i   in   32  load data
// - st_data_i   in   32  store data (rs2)
// - flush_i     in   1   synchronous FIFO clear
// - rec_vld_o   out  1   head record valid
// - rec_rdy_i   in   1   consumer accepts head record
// - rec_o       out  trace_rec_t  head record: seq, pc, instr, rd, kind, size, addr, data
// - level_o     out  $clog2(DEPTH)+1  occupancy
// - drop_cnt_o  out  DROP_W  records dropped; saturating
// - ovf_o       out  1   sticky overflow flag
// BEHAVIOUR
// - Reset: rec_vld_o=0, rec_o=0, level_o=0, drop_cnt_o=0, ovf_o=0; rd/wr pointers and seq counter = 0.
// - Classification (combinational, priority order):
//   - BRANCH > LOAD > STORE > JUMP (JAL/JALR/AUIPC) > DEFAULT.
//   - size one-hot: 001 word, 010 half, 100 byte; 000 when neither load nor store.
//   - rd = instr_i[11:7].
// - Record data field by kind: LOAD=ld_data_i, STORE=st_data_i, JUMP/DEFAULT=wb_data_i, BRANCH=0.
// - Every cycle with insn_vld_i=1: seq counter +1, wrapping. Record seq is the pre-increment value.
//   Dropped records consume a seq, so the consumer sees gaps.
// - Push: insn_vld_i && (!full || pop); the record is written at the clock edge.
// - Full with insn_vld_i && !pop:
//   - record discarded; drop_cnt_o +1, saturating at all-ones;
//   - ovf_o set, cleared only by rst_i.
// - Pop: rec_vld_o && rec_rdy_i; head advances at the clock edge.
// - Latency:
//   - pushed record visible on rec_o one cycle after capture; no same-cycle bypass.
//   - rec_o holds stable while rec_vld_o && !rec_rdy_i.
// - Simultaneous push+pop:
//   - when full, both happen, no drop, level unchanged;
//   - when empty, only the push takes effect (rec_vld_o=0 that cycle).
// - Pointers are $clog2(DEPTH)+1 bits; MSB distinguishes full from empty on wrap.
// - flush_i:
//   - clears pointers, level_o=0, rec_vld_o=0 next cycle;
//   - the same-cycle push is discarded, not counted as a drop;
//   - seq, drop_cnt_o and ovf_o are retained.
// - rst_i has priority over flush_i and over any push/pop in flight.
// STRUCTURE
// - Package trace_pkg holds:
//   - enum rec_kind_e {K_DEFAULT, K_BRANCH, K_LOAD, K_STORE, K_JUMP};
//   - struct trace_rec_t; size encodings.
//   - Reuses MASK_*/EXPT_* from package_decode.
// - Sub-module retire_classify: purely combinational, instr -> kind/size/rd.
// - Top level: seq counter, FIFO storage array, pointers, drop/ovf logic.
// TESTING
// - Reset, then 3 retires (pc 0x0,0x4,0x8), rec_rdy_i=1
//   -> records seq 0,1,2 each 1 cycle after capture; level_o back to 0.
// - LW x5 with ld_data 0xDEADBEEF, addr 0x7F0
//   -> kind LOAD, size 001, rd 5, data 0xDEADBEEF, addr 0x7F0.
// - SB with st_data 0x000000AB
//   -> kind STORE, size 100, data 0xAB. BEQ -> kind BRANCH, data 0.
// - DEPTH=16, rec_rdy_i=0, 20 retires
//   -> level_o=16, drop_cnt_o=4, ovf_o=1; drain yields seq 0..15.
// - Full FIFO, retire with rec_rdy_i=1 same cycle
//   -> no drop; level stays 16; next retire seq continues.
// - 5 queued, assert flush_i with concurrent retire
//   -> level_o=0, rec_vld_o=0, drop_cnt_o unchanged; next record seq = prior+2.

Source files
------------

// File: rtl/package_decode.sv
// rtl/package_decode.sv - RV32 opcode mask/expected-value pairs shared by decoders
package package_decode;

  localparam logic [31:0] MASK_BRANCH = 32'h0000_007F;
  localparam logic [31:0] EXPT_BRANCH = 32'h0000_0063;
  localparam logic [31:0] MASK_LOAD   = 32'h0000_007F;
  localparam logic [31:0] EXPT_LOAD   = 32'h0000_0003;
  localparam logic [31:0] MASK_STORE  = 32'h0000_007F;
  localparam logic [31:0] EXPT_STORE  = 32'h0000_0023;
  localparam logic [31:0] MASK_JAL    = 32'h0000_007F;
  localparam logic [31:0] EXPT_JAL    = 32'h0000_006F;
  localparam logic [31:0] MASK_JALR   = 32'h0000_707F;
  localparam logic [31:0] EXPT_JALR   = 32'h0000_0067;
  localparam logic [31:0] MASK_AUIPC  = 32'h0000_007F;
  localparam logic [31:0] EXPT_AUIPC  = 32'h0000_0017;

endpackage

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - retire trace record types, size encodings and helpers
package trace_pkg;

  localparam int TR_SEQ_W = 32;

  typedef enum logic [2:0] {
    K_DEFAULT = 3'd0,
    K_BRANCH  = 3'd1,
    K_LOAD    = 3'd2,
    K_STORE   = 3'd3,
    K_JUMP    = 3'd4
  } rec_kind_e;

  localparam logic [2:0] SZ_NONE = 3'b000;
  localparam logic [2:0] SZ_WORD = 3'b001;
  localparam logic [2:0] SZ_HALF = 3'b010;
  localparam logic [2:0] SZ_BYTE = 3'b100;

  typedef struct packed {
    logic [TR_SEQ_W-1:0] seq;
    logic [31:0]         pc;
    logic [31:0]         instr;
    logic [4:0]          rd;
    rec_kind_e           kind;
    logic [2:0]          size;
    logic [11:0]         addr;
    logic [31:0]         data;
  } trace_rec_t;

  function automatic logic insn_match(input logic [31:0] instr,
                                      input logic [31:0] mask,
                                      input logic [31:0] expt);
    return (instr & mask) == expt;
  endfunction

  // funct3[1:0] carries the access width for both loads and stores
  function automatic logic [2:0] size_from_funct3(input logic [2:0] funct3);
    logic [2:0] sz;
    case (funct3[1:0])
      2'b00:   sz = SZ_BYTE;
      2'b01:   sz = SZ_HALF;
      2'b10:   sz = SZ_WORD;
      default: sz = SZ_NONE;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/retire_classify.sv
// rtl/retire_classify.sv - combinational instruction classifier: kind, access size, rd
module retire_classify
  import trace_pkg::*;
  import package_decode::*;
(
  input  logic [31:0] instr_i,
  output rec_kind_e   kind_o,
  output logic [2:0]  size_o,
  output logic [4:0]  rd_o
);

  logic w_is_branch;
  logic w_is_load;
  logic w_is_store;
  logic w_is_jump;

  assign w_is_branch = insn_match(instr_i, MASK_BRANCH, EXPT_BRANCH);
  assign w_is_load   = insn_match(instr_i, MASK_LOAD,   EXPT_LOAD);
  assign w_is_store  = insn_match(instr_i, MASK_STORE,  EXPT_STORE);
  assign w_is_jump   = insn_match(instr_i, MASK_JAL,    EXPT_JAL)  ||
                       insn_match(instr_i, MASK_JALR,   EXPT_JALR) ||
                       insn_match(instr_i, MASK_AUIPC,  EXPT_AUIPC);

  assign rd_o = instr_i[11:7];

  always_comb begin
    kind_o = K_DEFAULT;
    size_o = SZ_NONE;
    if (w_is_branch) begin
      kind_o = K_BRANCH;
    end else if (w_is_load) begin
      kind_o = K_LOAD;
      size_o = size_from_funct3(instr_i[14:12]);
    end else if (w_is_store) begin
      kind_o = K_STORE;
      size_o = size_from_funct3(instr_i[14:12]);
    end else if (w_is_jump) begin
      kind_o = K_JUMP;
    end
  end

endmodule

// File: rtl/retire_trace_buf.sv
// rtl/retire_trace_buf.sv - retire record capture FIFO with sequence numbers and loss reporting
module retire_trace_buf
  import trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int SEQ_W  = 32,
  parameter int DROP_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     insn_vld_i,
  input  logic [31:0]              pc_i,
  input  logic [31:0]              instr_i,
  input  logic [31:0]              wb_data_i,
  input  logic [11:0]              ls_addr_i,
  input  logic [31:0]              ld_data_i,
  input  logic [31:0]              st_data_i,
  input  logic                     flush_i,
  output logic                     rec_vld_o,
  input  logic                     rec_rdy_i,
  output trace_rec_t               rec_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [DROP_W-1:0]        drop_cnt_o,
  output logic                     ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [SEQ_W-1:0]  r_seq;
  logic [DROP_W-1:0] r_drop;
  logic              r_ovf;
  trace_rec_t        r_mem [DEPTH];

  rec_kind_e   w_kind;
  logic [2:0]  w_size;
  logic [4:0]  w_rd;
  logic [31:0] w_data;
  trace_rec_t  w_rec;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;

  retire_classify u_classify (
    .instr_i (instr_i),
    .kind_o  (w_kind),
    .size_o  (w_size),
    .rd_o    (w_rd)
  );

  always_comb begin
    w_data = wb_data_i;
    case (w_kind)
      K_LOAD:   w_data = ld_data_i;
      K_STORE:  w_data = st_data_i;
      K_BRANCH: w_data = 32'h0;
      default:  w_data = wb_data_i;
    endcase
  end

  always_comb begin
    w_rec       = '0;
    w_rec.seq   = TR_SEQ_W'(r_seq);
    w_rec.pc    = pc_i;
    w_rec.instr = instr_i;
    w_rec.rd    = w_rd;
    w_rec.kind  = w_kind;
    w_rec.size  = w_size;
    w_rec.addr  = ls_addr_i;
    w_rec.data  = w_data;
  end

  // Pointer MSB differs only when the writer has lapped the reader
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && rec_rdy_i;
  assign w_push  = insn_vld_i && !flush_i && (!w_full || w_pop);
  assign w_drop  = insn_vld_i && !flush_i && w_full && !w_pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_seq    <= '0;
      r_drop   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (insn_vld_i) begin
        r_seq <= r_seq + SEQ_W'(1);
      end
      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != '1) begin
          r_drop <= r_drop + DROP_W'(1);
        end
      end
    end
  end

  // Storage carries no reset; rec_o is masked to zero while empty instead
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_rec;
    end
  end

  assign rec_vld_o  = !w_empty;
  assign rec_o      = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign level_o    = r_wr_ptr - r_rd_ptr;
  assign drop_cnt_o = r_drop;
  assign ovf_o      = r_ovf;

endmodule

// File: tb/tb_retire_trace_buf.sv
// tb/tb_retire_trace_buf.sv - self-checking bench for retire_trace_buf against a queue model
module tb_retire_trace_buf;
  import trace_pkg::*;

  localparam int DEPTH  = 16;
  localparam int SEQ_W  = 32;
  localparam int DROP_W = 5;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic                   clk_i = 1'b0;
  logic                   rst_i, insn_vld_i, flush_i, rec_rdy_i;
  logic [31:0]            pc_i, instr_i, wb_data_i, ld_data_i, st_data_i;
  logic [11:0]            ls_addr_i;
  logic                   rec_vld_o, ovf_o;
  trace_rec_t             rec_o;
  logic [$clog2(DEPTH):0] level_o;
  logic [DROP_W-1:0]      drop_cnt_o;

  always #5 clk_i = ~clk_i;

  retire_trace_buf #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .DROP_W(DROP_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .insn_vld_i(insn_vld_i), .pc_i(pc_i),
    .instr_i(instr_i), .wb_data_i(wb_data_i), .ls_addr_i(ls_addr_i),
    .ld_data_i(ld_data_i), .st_data_i(st_data_i), .flush_i(flush_i),
    .rec_vld_o(rec_vld_o), .rec_rdy_i(rec_rdy_i), .rec_o(rec_o),
    .level_o(level_o), .drop_cnt_o(drop_cnt_o), .ovf_o(ovf_o)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  trace_rec_t  m_q[$];
  logic [31:0] m_seq  = '0;
  int          m_drop = 0;
  logic        m_ovf  = 1'b0;
  logic [31:0] last_seq;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference record built straight from the RV32 opcode map
  function automatic trace_rec_t model_rec(input logic [31:0] instr, input logic [31:0] pc,
                                           input logic [31:0] wb, input logic [31:0] ld,
                                           input logic [31:0] st, input logic [11:0] addr,
                                           input logic [31:0] seq);
    trace_rec_t r;
    logic [2:0] sz;
    r = '0;
    r.seq = seq; r.pc = pc; r.instr = instr; r.rd = instr[11:7]; r.addr = addr;
    case (instr[13:12])
      2'd0: sz = 3'b100;
      2'd1: sz = 3'b010;
      2'd2: sz = 3'b001;
      default: sz = 3'b000;
    endcase
    case (instr[6:0])
      7'h63: begin r.kind = K_BRANCH; r.data = 32'h0; end
      7'h03: begin r.kind = K_LOAD;   r.data = ld; r.size = sz; end
      7'h23: begin r.kind = K_STORE;  r.data = st; r.size = sz; end
      7'h6F, 7'h17: begin r.kind = K_JUMP; r.data = wb; end
      7'h67: begin r.kind = (instr[14:12] == 3'd0) ? K_JUMP : K_DEFAULT; r.data = wb; end
      default: begin r.kind = K_DEFAULT; r.data = wb; end
    endcase
    return r;
  endfunction

  task automatic check_state();
    trace_rec_t e;
    e = (m_q.size() != 0) ? m_q[0] : '0;
    chk("rec_vld", 256'(rec_vld_o), 256'(m_q.size() != 0));
    chk("rec_o", 256'(rec_o), 256'(e));
    chk("level", 256'(level_o), 256'(m_q.size()));
    chk("drop_cnt", 256'(drop_cnt_o), 256'(m_drop));
    chk("ovf", 256'(ovf_o), 256'(m_ovf));
  endtask

  // Drive one cycle from a negedge, advance the model, check at the next negedge
  task automatic step(input logic vld, input logic rdy, input logic fl, input logic rs,
                      input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] wb,
                      input logic [31:0] ld, input logic [31:0] st, input logic [11:0] addr);
    bit pop, full;
    rst_i = rs; insn_vld_i = vld; rec_rdy_i = rdy; flush_i = fl;
    instr_i = instr; pc_i = pc; wb_data_i = wb; ld_data_i = ld; st_data_i = st; ls_addr_i = addr;
    if (rs) begin
      m_q.delete(); m_seq = '0; m_drop = 0; m_ovf = 1'b0;
    end else begin
      pop  = (m_q.size() != 0) && rdy;
      full = (m_q.size() == DEPTH);
      if (fl) begin
        m_q.delete();
      end else begin
        if (pop) void'(m_q.pop_front());
        if (vld) begin
          if (!full || pop) m_q.push_back(model_rec(instr, pc, wb, ld, st, addr, m_seq));
          else begin
            if (m_drop < DROP_MAX) m_drop++;
            m_ovf = 1'b1;
          end
        end
      end
      if (vld) m_seq = m_seq + 32'd1;
    end
    @(negedge clk_i);
    check_state();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    case ($urandom_range(0, 7))
      0: w[6:0] = 7'h63;
      1: begin w[6:0] = 7'h03; k = $urandom_range(0, 4); w[14:12] = (k < 3) ? 3'(k) : 3'(k + 1); end
      2: begin w[6:0] = 7'h23; w[14:12] = 3'($urandom_range(0, 2)); end
      3: w[6:0] = 7'h6F;
      4: w[6:0] = 7'h17;
      5: begin w[6:0] = 7'h67; if ($urandom_range(0, 1) == 0) w[14:12] = 3'd0; end
      6: w[6:0] = 7'h33;
      default: w[6:0] = 7'h13;
    endcase
    return w;
  endfunction

  task automatic retire(input logic rdy, input logic fl);
    step(1'b1, rdy, fl, 1'b0, rand_instr(), $urandom, $urandom, $urandom, $urandom, 12'($urandom));
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, rdy, 1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom, $urandom, 12'($urandom));
  endtask

  initial begin
    rst_i = 1'b1; insn_vld_i = 1'b0; flush_i = 1'b0; rec_rdy_i = 1'b0;
    pc_i = '0; instr_i = '0; wb_data_i = '0; ld_data_i = '0; st_data_i = '0; ls_addr_i = '0;
    @(negedge clk_i);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 12'h0);
    chk("reset_level", 256'(level_o), 256'(0));

    // Three retires with the consumer always ready
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 32'h0, 32'h11, 32'h0, 32'h0, 12'h0);
    chk("seq0", 256'(rec_o.seq), 256'(0));
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 32'h4, 32'h22, 32'h0, 32'h0, 12'h0);
    chk("seq1", 256'(rec_o.seq), 256'(1));
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 32'h8, 32'h33, 32'h0, 32'h0, 12'h0);
    chk("seq2", 256'(rec_o.seq), 256'(2));
    chk("pc2", 256'(rec_o.pc), 256'(32'h8));
    idle(1'b1);
    chk("drained_level", 256'(level_o), 256'(0));

    // LW x5 / SB / BEQ field checks
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0002_A283, 32'h100, 32'h5555, 32'hDEAD_BEEF, 32'h1, 12'h7F0);
    chk("lw_kind", 256'(rec_o.kind), 256'(K_LOAD));
    chk("lw_size", 256'(rec_o.size), 256'(3'b001));
    chk("lw_rd", 256'(rec_o.rd), 256'(5));
    chk("lw_data", 256'(rec_o.data), 256'(32'hDEAD_BEEF));
    chk("lw_addr", 256'(rec_o.addr), 256'(12'h7F0));
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h00B5_0023, 32'h104, 32'h5555, 32'h7777, 32'h0000_00AB, 12'h010);
    chk("sb_kind", 256'(rec_o.kind), 256'(K_STORE));
    chk("sb_size", 256'(rec_o.size), 256'(3'b100));
    chk("sb_data", 256'(rec_o.data), 256'(32'hAB));
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0063, 32'h108, 32'h5555, 32'h7777, 32'h8888, 12'h020);
    chk("beq_kind", 256'(rec_o.kind), 256'(K_BRANCH));
    chk("beq_data", 256'(rec_o.data), 256'(0));
    idle(1'b1);

    // Overflow: 20 retires into a stalled FIFO
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 12'h0);
    for (int i = 0; i < 20; i++) retire(1'b0, 1'b0);
    chk("ovf_level", 256'(level_o), 256'(16));
    chk("ovf_drop", 256'(drop_cnt_o), 256'(4));
    chk("ovf_flag", 256'(ovf_o), 256'(1));
    chk("ovf_head", 256'(rec_o.seq), 256'(0));
    retire(1'b1, 1'b0);
    chk("full_pp_level", 256'(level_o), 256'(16));
    chk("full_pp_drop", 256'(drop_cnt_o), 256'(4));
    for (int i = 1; i < 16; i++) begin
      chk("drain_seq", 256'(rec_o.seq), 256'(i));
      idle(1'b1);
    end
    chk("tail_seq", 256'(rec_o.seq), 256'(20));
    idle(1'b1);

    // Flush with a concurrent retire
    for (int i = 0; i < 5; i++) retire(1'b0, 1'b0);
    last_seq = m_seq - 32'd1;
    retire(1'b0, 1'b1);
    chk("flush_level", 256'(level_o), 256'(0));
    chk("flush_vld", 256'(rec_vld_o), 256'(0));
    chk("flush_drop", 256'(drop_cnt_o), 256'(4));
    retire(1'b0, 1'b0);
    chk("post_flush_seq", 256'(rec_o.seq), 256'(last_seq + 32'd2));

    // Drop counter saturation
    for (int i = 0; i < 50; i++) retire(1'b0, 1'b0);
    chk("drop_sat", 256'(drop_cnt_o), 256'(DROP_MAX));

    // Randomized traffic with varying consumer throughput
    for (int ph = 0; ph < 6; ph++) begin
      int thr;
      thr = $urandom_range(1, 8);
      for (int i = 0; i < 100; i++) begin
        step(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) < thr),
             ($urandom_range(0, 63) == 0), ($urandom_range(0, 299) == 0),
             rand_instr(), $urandom, $urandom, $urandom, $urandom, 12'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
